sid_envelope_bank: RTL and testbench
====================================

SID_ENVELOPE_BANK -- requirements
Module: sid_envelope_bank

Interface
REQ-001 SHALL have parameter VOICES, default 3, number of independent ADSR envelope channels.
REQ-002 SHALL have parameter RATE_W, default 15, rate-counter width in bits (minimum 15).
REQ-003 SHALL have port clock  input  1  system clock; all logic rising-edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ce_1m  input  1  1 MHz clock enable; envelope logic advances only when high.
REQ-006 SHALL have port gate  input  VOICES  per-voice gate; bit v = voice v.
REQ-007 SHALL have port att_dec  input  8*VOICES  per-voice {attack[7:4], decay[3:0]}; byte v = voice v.
REQ-008 SHALL have port sus_rel  input  8*VOICES  per-voice {sustain[7:4], release[3:0]}.
REQ-009 SHALL have port envelope  output  8*VOICES  per-voice envelope level, registered.
REQ-010 SHALL have port env_state  output  2*VOICES  per-voice state: 0 RELEASE, 1 ATTACK, 2 DEC_SUS.
REQ-011 SHALL have port env_sel  input  2  voice index for readback.
REQ-012 SHALL have port env_rd  output  8  registered envelope of voice env_sel (0 if env_sel >= VOICES), one clock latency.

Function
REQ-013 Each voice SHALL have private state, rate counter, exponential counter, exponential period and hold_zero; no state is shared between voices.
REQ-014 Rate period SHALL be selected by nibble: attack in ATTACK, decay in DEC_SUS, release in RELEASE; table 0..15 = 8,31,62,94,148,219,266,312,391,976,1953,3125,3906,11719,19531,31250.
REQ-015 On ce_1m the rate counter SHALL increment modulo 2^RATE_W; when it equals the period, it SHALL instead load 0 and issue a rate step (period+1 ce per step).
REQ-016 Period lowered below the current counter SHALL NOT force a step; the counter runs to 2^RATE_W-1, wraps to 0 and then matches (ADSR delay bug).
REQ-017 On a rate step in ATTACK, the envelope SHALL increment by 1 regardless of exponential counter; reaching 0xFF (from 0xFE) SHALL transition to DEC_SUS.
REQ-018 On a rate step outside ATTACK, the exponential counter SHALL increment, and when equal to the exponential period it SHALL load 0 and issue an envelope step.
REQ-019 Exponential period SHALL be updated each clock from the current envelope: 0xFF->0, 0x5D->1, 0x36->3, 0x1A->7, 0x0E->15, 0x06->29, 0x00->0; other values hold.
REQ-020 DEC_SUS envelope step SHALL decrement unless envelope == {sustain,sustain} or hold_zero; a sustain above the current level SHALL NOT raise the envelope.
REQ-021 RELEASE envelope step SHALL decrement unless hold_zero.
REQ-022 A non-ATTACK envelope step taken at envelope 0x01 SHALL set hold_zero; the envelope then freezes at 0x00.
REQ-023 Gate rising edge (gate registered vs. previous ce sample) SHALL set state ATTACK and clear hold_zero; falling edge SHALL set RELEASE.
REQ-024 A gate edge SHALL take priority over a same-cycle ATTACK->DEC_SUS transition; the envelope step of that cycle still applies.
REQ-025 Gate edges SHALL be sampled only on ce_1m cycles; envelope and rate counter SHALL NOT reset on gate edges.
REQ-026 With ce_1m low, all voice registers except exponential period SHALL hold.

Reset
REQ-027 During reset: envelope=0, env_state=RELEASE, hold_zero=1, rate and exponential counters=0, exponential period=0, gate history=current gate, env_rd=0.
REQ-028 Reset SHALL override ce_1m and any gate edge in the same cycle; reset mid-attack SHALL return the voice to the reset values on the next clock.

Verification
REQ-029 Voice 0, att_dec=0x00, gate 0->1, ce_1m always high -> envelope 0x00->0xFF after 255*9=2295 ce, env_state=2 the same clock.
REQ-030 After REQ-029, sus_rel=0x80, decay 0 -> envelope descends to 0x88 and holds; step spacing 9 ce above 0x5D, 18 ce at/below 0x5D.
REQ-031 Gate 1->0 at envelope 0x88, release 0 -> envelope reaches 0x00, hold_zero set, stays 0x00 for 100000 ce.
REQ-032 Release nibble 0xF, counter at 20000, change to 0x0 -> no step until counter wraps at 32767->0, next step 9 ce later.
REQ-033 Voices 0/1/2 gated with attack 0/1/2 simultaneously -> each envelope ramps at its own rate, env_rd tracks env_sel with 1-clock latency, env_sel=3 -> env_rd=0.
REQ-034 Reset asserted mid-attack at envelope 0x40 with gate held high -> envelope=0, env_state=0; no re-attack until gate falls and rises again.

Source files
------------

// File: rtl/sid_envelope_bank.sv
// Bank of independent SID-style ADSR envelope generators advanced by a 1 MHz enable,
// reproducing the original chip's rate-counter delay bug and exponential decay.
module sid_envelope_bank #(
    parameter int VOICES = 3,
    parameter int RATE_W = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ce_1m,
    input  logic [VOICES-1:0]     gate,
    input  logic [8*VOICES-1:0]   att_dec,
    input  logic [8*VOICES-1:0]   sus_rel,
    output logic [8*VOICES-1:0]   envelope,
    output logic [2*VOICES-1:0]   env_state,
    input  logic [1:0]            env_sel,
    output logic [7:0]            env_rd
);

    localparam logic [1:0] ST_RELEASE = 2'd0;
    localparam logic [1:0] ST_ATTACK  = 2'd1;
    localparam logic [1:0] ST_DEC_SUS = 2'd2;

    function automatic logic [14:0] rate_period(input logic [3:0] nib);
        case (nib)
            4'd0:    rate_period = 15'd8;
            4'd1:    rate_period = 15'd31;
            4'd2:    rate_period = 15'd62;
            4'd3:    rate_period = 15'd94;
            4'd4:    rate_period = 15'd148;
            4'd5:    rate_period = 15'd219;
            4'd6:    rate_period = 15'd266;
            4'd7:    rate_period = 15'd312;
            4'd8:    rate_period = 15'd391;
            4'd9:    rate_period = 15'd976;
            4'd10:   rate_period = 15'd1953;
            4'd11:   rate_period = 15'd3125;
            4'd12:   rate_period = 15'd3906;
            4'd13:   rate_period = 15'd11719;
            4'd14:   rate_period = 15'd19531;
            default: rate_period = 15'd31250;
        endcase
    endfunction

    logic [7:0] env_arr [VOICES];

    genvar gi;
    generate
        for (gi = 0; gi < VOICES; gi++) begin : g_voice
            logic [7:0]        env_q, env_d;
            logic [1:0]        state_q, state_d;
            logic [RATE_W-1:0] rate_q, rate_d;
            logic [4:0]        exp_cnt_q, exp_cnt_d;
            logic [4:0]        exp_per_q, exp_per_d;
            logic              hold_q, hold_d;
            logic              gate_q, gate_d;
            logic [7:0]        ad, sr;
            logic [3:0]        nib;
            logic [RATE_W-1:0] period;
            logic              rate_step, env_step;

            assign ad     = att_dec[gi*8 +: 8];
            assign sr     = sus_rel[gi*8 +: 8];
            assign period = RATE_W'(rate_period(nib));

            always_comb begin
                case (state_q)
                    ST_ATTACK:  nib = ad[7:4];
                    ST_DEC_SUS: nib = ad[3:0];
                    default:    nib = sr[3:0];
                endcase
            end

            always_comb begin
                env_d     = env_q;
                state_d   = state_q;
                rate_d    = rate_q;
                exp_cnt_d = exp_cnt_q;
                hold_d    = hold_q;
                gate_d    = gate_q;
                rate_step = 1'b0;
                env_step  = 1'b0;

                // Exponential period tracks the level every clock, independent of ce_1m.
                case (env_q)
                    8'hFF:   exp_per_d = 5'd0;
                    8'h5D:   exp_per_d = 5'd1;
                    8'h36:   exp_per_d = 5'd3;
                    8'h1A:   exp_per_d = 5'd7;
                    8'h0E:   exp_per_d = 5'd15;
                    8'h06:   exp_per_d = 5'd29;
                    8'h00:   exp_per_d = 5'd0;
                    default: exp_per_d = exp_per_q;
                endcase

                if (ce_1m) begin
                    gate_d = gate[gi];
                    // Exact-match compare: a lowered period lets the counter run through the wrap.
                    if (rate_q == period) begin
                        rate_d    = '0;
                        rate_step = 1'b1;
                    end else begin
                        rate_d = rate_q + 1'b1;
                    end

                    if (rate_step) begin
                        if (state_q == ST_ATTACK) begin
                            exp_cnt_d = 5'd0;
                            env_d     = env_q + 8'd1;
                            if (env_q == 8'hFE) state_d = ST_DEC_SUS;
                        end else if (exp_cnt_q == exp_per_q) begin
                            exp_cnt_d = 5'd0;
                            env_step  = 1'b1;
                        end else begin
                            exp_cnt_d = exp_cnt_q + 5'd1;
                        end
                    end

                    if (env_step && !hold_q) begin
                        if (state_q != ST_DEC_SUS || env_q != {sr[7:4], sr[7:4]}) begin
                            env_d = env_q - 8'd1;
                            if (env_q == 8'h01) hold_d = 1'b1;
                        end
                    end

                    if (gate[gi] && !gate_q) begin
                        state_d = ST_ATTACK;
                        hold_d  = 1'b0;
                    end else if (!gate[gi] && gate_q) begin
                        state_d = ST_RELEASE;
                    end
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    env_q     <= 8'h00;
                    state_q   <= ST_RELEASE;
                    rate_q    <= '0;
                    exp_cnt_q <= 5'd0;
                    exp_per_q <= 5'd0;
                    hold_q    <= 1'b1;
                    gate_q    <= gate[gi];
                end else begin
                    env_q     <= env_d;
                    state_q   <= state_d;
                    rate_q    <= rate_d;
                    exp_cnt_q <= exp_cnt_d;
                    exp_per_q <= exp_per_d;
                    hold_q    <= hold_d;
                    gate_q    <= gate_d;
                end
            end

            assign envelope[gi*8 +: 8]  = env_q;
            assign env_state[gi*2 +: 2] = state_q;
            assign env_arr[gi]          = env_q;
        end
    endgenerate

    logic [7:0] env_rd_q, env_rd_d;

    always_comb begin
        env_rd_d = 8'h00;
        if (32'(env_sel) < VOICES) env_rd_d = env_arr[env_sel];
    end

    always_ff @(posedge clock) begin
        if (reset) env_rd_q <= 8'h00;
        else       env_rd_q <= env_rd_d;
    end

    assign env_rd = env_rd_q;

endmodule

// File: tb/tb_sid_envelope_bank.sv
// Directed bench for sid_envelope_bank: attack/decay/release timing, delay bug,
// multi-voice readback and reset behaviour, with hand-computed expectations.
module tb_sid_envelope_bank;

    logic        clock = 1'b0;
    logic        reset;
    logic        ce_1m;
    logic [2:0]  gate;
    logic [23:0] att_dec;
    logic [23:0] sus_rel;
    logic [23:0] envelope;
    logic [5:0]  env_state;
    logic [1:0]  env_sel;
    logic [7:0]  env_rd;

    int n_cmp = 0;
    int n_bad = 0;
    int n;

    always #5 clock = ~clock;

    sid_envelope_bank #(.VOICES(3), .RATE_W(15)) dut (
        .clock     (clock),
        .reset     (reset),
        .ce_1m     (ce_1m),
        .gate      (gate),
        .att_dec   (att_dec),
        .sus_rel   (sus_rel),
        .envelope  (envelope),
        .env_state (env_state),
        .env_sel   (env_sel),
        .env_rd    (env_rd)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) @(posedge clock);
        #1;
    endtask

    task automatic wait_env(input logic [7:0] val, input int bound, output int cnt);
        cnt = 0;
        while (envelope[7:0] !== val && cnt < bound) begin
            @(posedge clock);
            #1;
            cnt++;
        end
    endtask

    task automatic measure_step(input logic [7:0] from, input int exp_gap, input string tag);
        int cnt;
        int gap;
        logic [7:0] nxt;
        wait_env(from, 20000, cnt);
        gap = 0;
        while (envelope[7:0] === from && gap < 2000) begin
            @(posedge clock);
            #1;
            gap++;
        end
        nxt = from - 8'd1;
        check_eq({tag, "_gap"}, gap, exp_gap);
        check_eq({tag, "_val"}, envelope[7:0], nxt);
    endtask

    task automatic enter_reset();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        ce_1m   = 1'b1;
        gate    = 3'b000;
        att_dec = 24'h000000;
        sus_rel = 24'h000080;
        env_sel = 2'd0;
        tick(3);
        check_eq("rst_env",   envelope,  24'h0);
        check_eq("rst_state", env_state, 6'h0);
        check_eq("rst_rd",    env_rd,    8'h0);

        // Attack 0: 255 steps of 9 ce, gate sampled on the first edge.
        @(negedge clock);
        reset = 1'b0;
        gate  = 3'b001;
        wait_env(8'hFF, 5000, n);
        check_eq("atk_cycles", n, 2295);
        check_eq("atk_state",  env_state[1:0], 2'd2);
        check_eq("atk_rd_lat", env_rd, 8'hFE);

        // Decay 0 to sustain 8.
        measure_step(8'hFF, 9, "dec_ff");
        wait_env(8'h88, 3000, n);
        check_eq("dec_cycles", n, 1062);
        tick(300);
        check_eq("dec_hold",  envelope[7:0],  8'h88);
        check_eq("dec_state", env_state[1:0], 2'd2);

        // Release 0 with exponential slow-down, then freeze at zero.
        @(negedge clock);
        gate = 3'b000;
        measure_step(8'h70, 9,  "rel_70");
        measure_step(8'h5D, 18, "rel_5d");
        measure_step(8'h30, 36, "rel_30");
        wait_env(8'h00, 10000, n);
        check_eq("rel_zero", envelope[7:0], 8'h00);
        tick(2000);
        check_eq("rel_hold",  envelope[7:0],  8'h00);
        check_eq("rel_state", env_state[1:0], 2'd0);

        // Delay bug: release F counter at 20000, then release 0.
        sus_rel = 24'h0000FF;
        enter_reset();
        @(negedge clock);
        reset = 1'b0;
        gate  = 3'b001;
        wait_env(8'hFF, 5000, n);
        check_eq("dly_atk", n, 2295);
        @(negedge clock);
        gate = 3'b000;
        tick(20000);
        check_eq("dly_hold",  envelope[7:0],  8'hFF);
        check_eq("dly_state", env_state[1:0], 2'd0);
        @(negedge clock);
        sus_rel = 24'h0000F0;
        n = 0;
        while (envelope[7:0] === 8'hFF && n < 20000) begin
            @(posedge clock);
            #1;
            n++;
        end
        check_eq("dly_gap", n, 12777);
        check_eq("dly_val", envelope[7:0], 8'hFE);

        // Three voices at attack rates 0/1/2 (9/32/63 ce per step).
        sus_rel = 24'h000000;
        att_dec = 24'h201000;
        enter_reset();
        @(negedge clock);
        reset = 1'b0;
        gate  = 3'b111;
        tick(630);
        check_eq("mv_v0",    envelope[7:0],   8'h46);
        check_eq("mv_v1",    envelope[15:8],  8'h13);
        check_eq("mv_v2",    envelope[23:16], 8'h0A);
        check_eq("mv_state", env_state,       6'b010101);
        @(negedge clock);
        ce_1m   = 1'b0;
        env_sel = 2'd1;
        @(posedge clock);
        #1;
        check_eq("rd_v1", env_rd, 8'h13);
        @(negedge clock);
        env_sel = 2'd2;
        #1;
        check_eq("rd_lat", env_rd, 8'h13);
        @(posedge clock);
        #1;
        check_eq("rd_v2", env_rd, 8'h0A);
        @(negedge clock);
        env_sel = 2'd3;
        @(posedge clock);
        #1;
        check_eq("rd_none", env_rd, 8'h00);
        tick(20);
        check_eq("ce_hold", envelope, 24'h0A1346);

        // Reset mid-attack with gate held high.
        @(negedge clock);
        ce_1m   = 1'b1;
        gate    = 3'b000;
        env_sel = 2'd0;
        att_dec = 24'h000000;
        enter_reset();
        @(negedge clock);
        reset = 1'b0;
        gate  = 3'b001;
        wait_env(8'h40, 1000, n);
        check_eq("r7_reach", n, 576);
        enter_reset();
        check_eq("r7_env",   envelope[7:0],  8'h00);
        check_eq("r7_state", env_state[1:0], 2'd0);
        check_eq("r7_rd",    env_rd,         8'h00);
        @(negedge clock);
        reset = 1'b0;
        tick(100);
        check_eq("r7_noatk_env",   envelope[7:0],  8'h00);
        check_eq("r7_noatk_state", env_state[1:0], 2'd0);
        @(negedge clock);
        gate = 3'b000;
        tick(3);
        @(negedge clock);
        gate = 3'b001;
        tick(20);
        check_eq("r7_reatk_state", env_state[1:0], 2'd1);
        check_eq("r7_reatk_env",   (envelope[7:0] != 8'h00), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
